// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline controller: FSM encodings, the
// exception vector default, stage indices and the per-cycle control bundle.
package pipe_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0008;
  localparam int          NUM_STAGES         = 5;
  localparam int          REG_AW             = 5;

  // Bit positions inside the stage rst/en vectors
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_VECTOR = 2'd1,
    ST_RETURN = 2'd2
  } state_e;

  typedef struct packed {
    logic [NUM_STAGES-1:0] rst;
    logic [NUM_STAGES-1:0] en;
    logic                  epc_ctrl;
    logic                  epc_vec;
    logic                  irq_ack;
  } stage_ctrl_t;

  function automatic logic src_hit(input logic used,
                                   input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use detector: flags an ID-stage read of the register a load in EXE is
// about to write. r0 is never a real dependency.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic              mem_ren_exe,
  input  logic              wb_wen_exe,
  input  logic [REG_AW-1:0] regw_addr_exe,
  input  logic [REG_AW-1:0] addr_rs,
  input  logic [REG_AW-1:0] addr_rt,
  input  logic              rs_used,
  input  logic              rt_used,
  output logic              hazard
);

  logic load_wr;

  assign load_wr = mem_ren_exe && wb_wen_exe && (regw_addr_exe != '0);
  assign hazard  = load_wr && (src_hit(rs_used, addr_rs, regw_addr_exe) ||
                               src_hit(rt_used, addr_rt, regw_addr_exe));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush and interrupt controller: freeze on memory wait,
// single bubble on load-use, interrupt entry via VECTOR and ERET via RETURN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ready,
  input  logic        id_valid,
  input  logic [4:0]  addr_rs,
  input  logic [4:0]  addr_rt,
  input  logic        rs_used,
  input  logic        rt_used,
  input  logic        mem_ren_exe,
  input  logic        wb_wen_exe,
  input  logic [4:0]  regw_addr_exe,
  input  logic        is_eret_id,
  input  logic        irq,
  input  logic [31:0] cp0_return_addr,
  output logic        if_rst,
  output logic        id_rst,
  output logic        exe_rst,
  output logic        mem_rst,
  output logic        wb_rst,
  output logic        if_en,
  output logic        id_en,
  output logic        exe_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        epc_ctrl,
  output logic [31:0] epc,
  output logic        irq_ack,
  output logic        ie,
  output logic [31:0] stall_cnt
);

  state_e      state, state_nxt;
  stage_ctrl_t ctrl;
  logic        hazard, freeze, accept_irq, accept_eret;
  logic        ie_q;
  logic [31:0] epc_reg, stall_cnt_q;

  pipe_ctrl_hazard_detect u_hazard (
    .mem_ren_exe   (mem_ren_exe),
    .wb_wen_exe    (wb_wen_exe),
    .regw_addr_exe (regw_addr_exe),
    .addr_rs       (addr_rs),
    .addr_rt       (addr_rt),
    .rs_used       (rs_used),
    .rt_used       (rt_used),
    .hazard        (hazard)
  );

  assign freeze = !mem_ready;

  // Events are only taken in RUN, and a stalled or frozen cycle takes nothing,
  // so a blocked irq/ERET simply retries on the next clean cycle.
  assign accept_irq  = (state == ST_RUN) && irq && ie_q && !hazard && !freeze;
  assign accept_eret = (state == ST_RUN) && id_valid && is_eret_id &&
                       !hazard && !freeze && !accept_irq;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!freeze) begin
      unique case (state)
        ST_RUN: begin
          if (accept_irq)       state_nxt = ST_VECTOR;
          else if (accept_eret) state_nxt = ST_RETURN;
        end
        ST_VECTOR: state_nxt = ST_RUN;
        ST_RETURN: state_nxt = ST_RUN;
        default:   state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    ctrl          = '0;
    ctrl.en       = '1;
    if (!rst_n) begin
      ctrl.rst    = '1;
      ctrl.en     = '0;
    end else if (freeze) begin
      ctrl.en     = '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          // Hold IF/ID and squash EXE; the load keeps draining into MEM/WB
          if (hazard) begin
            ctrl.en[STG_IF]   = 1'b0;
            ctrl.en[STG_ID]   = 1'b0;
            ctrl.rst[STG_EXE] = 1'b1;
          end
        end
        ST_VECTOR: begin
          ctrl.epc_ctrl    = 1'b1;
          ctrl.epc_vec     = 1'b1;
          ctrl.irq_ack     = 1'b1;
          ctrl.rst[STG_ID] = 1'b1;
        end
        ST_RETURN: begin
          ctrl.epc_ctrl    = 1'b1;
          ctrl.rst[STG_ID] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ie_q        <= 1'b1;
      epc_reg     <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept_irq) begin
        epc_reg <= cp0_return_addr;
        ie_q    <= 1'b0;
      end else if (state == ST_RETURN && !freeze) begin
        ie_q    <= 1'b1;
      end
      if (!ctrl.en[STG_IF]) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign {wb_rst, mem_rst, exe_rst, id_rst, if_rst} = ctrl.rst;
  assign {wb_en,  mem_en,  exe_en,  id_en,  if_en } = ctrl.en;
  assign epc_ctrl  = ctrl.epc_ctrl;
  assign epc       = ctrl.epc_vec ? EXC_VECTOR : epc_reg;
  assign irq_ack   = ctrl.irq_ack;
  assign ie        = ie_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, interrupt entry/return, freeze,
// reset during VECTOR and stall counter wrap.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, mem_ready, id_valid, rs_used, rt_used;
  logic [4:0]  addr_rs, addr_rt, regw_addr_exe;
  logic        mem_ren_exe, wb_wen_exe, is_eret_id, irq;
  logic [31:0] cp0_return_addr;
  logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic        if_en, id_en, exe_en, mem_en, wb_en;
  logic        epc_ctrl, irq_ack, ie;
  logic [31:0] epc, stall_cnt;
  logic [4:0]  ens, rsts;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ens  = {wb_en, mem_en, exe_en, id_en, if_en};
  assign rsts = {wb_rst, mem_rst, exe_rst, id_rst, if_rst};

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .id_valid(id_valid),
    .addr_rs(addr_rs), .addr_rt(addr_rt), .rs_used(rs_used), .rt_used(rt_used),
    .mem_ren_exe(mem_ren_exe), .wb_wen_exe(wb_wen_exe),
    .regw_addr_exe(regw_addr_exe), .is_eret_id(is_eret_id), .irq(irq),
    .cp0_return_addr(cp0_return_addr),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst),
    .wb_rst(wb_rst), .if_en(if_en), .id_en(id_en), .exe_en(exe_en),
    .mem_en(mem_en), .wb_en(wb_en), .epc_ctrl(epc_ctrl), .epc(epc),
    .irq_ack(irq_ack), .ie(ie), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    mem_ready = 1'b1; id_valid = 1'b0; is_eret_id = 1'b0; irq = 1'b0;
    rs_used = 1'b0; rt_used = 1'b0; addr_rs = '0; addr_rt = '0;
    mem_ren_exe = 1'b0; wb_wen_exe = 1'b0; regw_addr_exe = '0;
    cp0_return_addr = '0;
  endtask

  task automatic load_use(input logic [4:0] r);
    mem_ren_exe = 1'b1; wb_wen_exe = 1'b1; regw_addr_exe = r;
    addr_rs = r; rs_used = 1'b1; id_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    // Reset state
    tick();
    chk("rst_rsts", 32'(rsts), 32'h1f);
    chk("rst_ens", 32'(ens), 32'h0);
    chk("rst_epc_ctrl", 32'(epc_ctrl), 32'h0);
    chk("rst_irq_ack", 32'(irq_ack), 32'h0);
    chk("rst_ie", 32'(ie), 32'h1);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    rst_n = 1'b1; #1;
    chk("run_ens", 32'(ens), 32'h1f);
    chk("run_rsts", 32'(rsts), 32'h0);
    chk("run_epc", epc, 32'h0);

    // Load r5, add r6,r5,r7 in ID
    tick();
    load_use(5'd5); addr_rt = 5'd7; rt_used = 1'b1; #1;
    chk("hz_rs_ens", 32'(ens), 32'h1c);
    chk("hz_rs_rsts", 32'(rsts), 32'h04);
    tick();
    idle(); #1;
    chk("hz_rs_after_ens", 32'(ens), 32'h1f);
    chk("hz_rs_cnt", stall_cnt, 32'd1);

    // rt-side dependency
    tick();
    mem_ren_exe = 1'b1; wb_wen_exe = 1'b1; regw_addr_exe = 5'd9;
    addr_rs = 5'd3; rs_used = 1'b1; addr_rt = 5'd9; rt_used = 1'b1; #1;
    chk("hz_rt_ens", 32'(ens), 32'h1c);
    tick();
    idle(); #1;
    chk("hz_rt_cnt", stall_cnt, 32'd2);

    // Non-hazards: r0 destination, unused source, non-writing EXE op
    tick();
    load_use(5'd0); #1;
    chk("r0_ens", 32'(ens), 32'h1f);
    chk("r0_rsts", 32'(rsts), 32'h0);
    regw_addr_exe = 5'd9; addr_rs = 5'd3; addr_rt = 5'd9; rt_used = 1'b0; #1;
    chk("unused_rt_ens", 32'(ens), 32'h1f);
    rt_used = 1'b1; wb_wen_exe = 1'b0; #1;
    chk("no_wen_ens", 32'(ens), 32'h1f);
    tick();
    idle(); #1;
    chk("nohz_cnt", stall_cnt, 32'd2);

    // Interrupt entry
    irq = 1'b1; cp0_return_addr = 32'h40; #1;
    chk("irq_acc_epc_ctrl", 32'(epc_ctrl), 32'h0);
    chk("irq_acc_ens", 32'(ens), 32'h1f);
    tick();
    chk("vec_epc_ctrl", 32'(epc_ctrl), 32'h1);
    chk("vec_epc", epc, 32'h8);
    chk("vec_irq_ack", 32'(irq_ack), 32'h1);
    chk("vec_rsts", 32'(rsts), 32'h02);
    chk("vec_ens", 32'(ens), 32'h1f);
    chk("vec_ie", 32'(ie), 32'h0);
    irq = 1'b0;
    tick();
    // ie=0 masks a new request
    irq = 1'b1; #1;
    chk("masked_epc", epc, 32'h40);
    tick();
    chk("masked_epc_ctrl", 32'(epc_ctrl), 32'h0);
    chk("masked_irq_ack", 32'(irq_ack), 32'h0);
    irq = 1'b0; id_valid = 1'b1; is_eret_id = 1'b1; #1;
    chk("eret_acc_epc_ctrl", 32'(epc_ctrl), 32'h0);
    tick();
    id_valid = 1'b0; is_eret_id = 1'b0; #1;
    chk("ret_epc_ctrl", 32'(epc_ctrl), 32'h1);
    chk("ret_epc", epc, 32'h40);
    chk("ret_rsts", 32'(rsts), 32'h02);
    chk("ret_ie_before", 32'(ie), 32'h0);
    tick();
    chk("ret_ie_after", 32'(ie), 32'h1);
    chk("ret_done_epc_ctrl", 32'(epc_ctrl), 32'h0);

    // Freeze for three cycles with a pending interrupt
    irq = 1'b1; cp0_return_addr = 32'h100; mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("frz%0d_ens", i), 32'(ens), 32'h0);
      chk($sformatf("frz%0d_rsts", i), 32'(rsts), 32'h0);
      chk($sformatf("frz%0d_epc_ctrl", i), 32'(epc_ctrl), 32'h0);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("frz_cnt", stall_cnt, 32'd5);
    chk("frz_rel_ens", 32'(ens), 32'h1f);
    chk("frz_rel_irq_ack", 32'(irq_ack), 32'h0);
    tick();
    chk("frz_vec_epc", epc, 32'h8);
    chk("frz_vec_irq_ack", 32'(irq_ack), 32'h1);
    // Freeze while in VECTOR holds the state
    mem_ready = 1'b0; #1;
    chk("vec_frz_epc_ctrl", 32'(epc_ctrl), 32'h0);
    chk("vec_frz_irq_ack", 32'(irq_ack), 32'h0);
    tick();
    mem_ready = 1'b1; #1;
    chk("vec_hold_irq_ack", 32'(irq_ack), 32'h1);
    chk("vec_hold_cnt", stall_cnt, 32'd6);

    // Reset asserted during VECTOR discards it
    rst_n = 1'b0; irq = 1'b0; #1;
    chk("vrst_rsts", 32'(rsts), 32'h1f);
    chk("vrst_ens", 32'(ens), 32'h0);
    chk("vrst_epc_ctrl", 32'(epc_ctrl), 32'h0);
    chk("vrst_irq_ack", 32'(irq_ack), 32'h0);
    tick();
    chk("vrst_ie", 32'(ie), 32'h1);
    chk("vrst_cnt", stall_cnt, 32'h0);
    chk("vrst_rsts2", 32'(rsts), 32'h1f);
    rst_n = 1'b1; #1;
    chk("vrst_rel_epc_ctrl", 32'(epc_ctrl), 32'h0);
    chk("vrst_rel_irq_ack", 32'(irq_ack), 32'h0);
    chk("vrst_rel_epc", epc, 32'h0);

    // Simultaneous irq and ERET: interrupt wins, ERET resumes afterwards
    tick();
    irq = 1'b1; id_valid = 1'b1; is_eret_id = 1'b1; cp0_return_addr = 32'h200; #1;
    chk("pri_ens", 32'(ens), 32'h1f);
    tick();
    idle(); #1;
    chk("pri_epc", epc, 32'h8);
    chk("pri_irq_ack", 32'(irq_ack), 32'h1);
    tick();
    id_valid = 1'b1; is_eret_id = 1'b1;
    tick();
    idle(); #1;
    chk("pri_ret_epc_ctrl", 32'(epc_ctrl), 32'h1);
    chk("pri_ret_epc", epc, 32'h200);
    tick();

    // Load-use outranks a pending interrupt
    irq = 1'b1; cp0_return_addr = 32'h300; load_use(5'd4); #1;
    chk("hz_irq_ens", 32'(ens), 32'h1c);
    tick();
    mem_ren_exe = 1'b0; wb_wen_exe = 1'b0; #1;
    chk("hz_irq_epc_ctrl", 32'(epc_ctrl), 32'h0);
    chk("hz_irq_cnt", stall_cnt, 32'd1);
    tick();
    chk("hz_irq_vec_epc", epc, 32'h8);
    chk("hz_irq_vec_ack", 32'(irq_ack), 32'h1);
    idle();
    tick();

    // Counter wrap
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    #1;
    chk("wrap_preload", stall_cnt, 32'hFFFF_FFFF);
    load_use(5'd6); #1;
    tick();
    idle(); #1;
    chk("wrap_zero", stall_cnt, 32'h0);
    tick();
    chk("wrap_hold", stall_cnt, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
